// File: rtl/wall_renderer_pkg.sv
// ============================================================================
// Module      : game_params (package)
// Description : Shared screen geometry, colours and renderer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_params;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int WALL_WIDTH   = 10;
    localparam int HOLE_HEIGHT  = 50;
    localparam int WALL_X_START = 150;

    localparam logic [2:0] WALL_COLOUR       = 3'b100;
    localparam logic [2:0] BACKGROUND_COLOUR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } render_state_t;

endpackage

`default_nettype wire

// File: rtl/wall_renderer_raster_counter.sv
// ============================================================================
// Module      : raster_counter
// Description : Nested column/row counter; row is the fast index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 120,
    parameter int COL_W  = 4,
    parameter int ROW_W  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (en) begin
            if (r_row == c_ROW_MAX) begin
                r_row <= '0;
                r_col <= (r_col == c_COL_MAX) ? '0 : r_col + 1'b1;
            end else begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);

endmodule

`default_nettype wire

// File: rtl/wall_renderer.sv
// ============================================================================
// Module      : wall_renderer
// Description : Rasterises the wall footprint as one VGA pixel write per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wall_renderer #(
    parameter int         SCREEN_W          = game_params::SCREEN_W,
    parameter int         SCREEN_H          = game_params::SCREEN_H,
    parameter int         WALL_WIDTH        = game_params::WALL_WIDTH,
    parameter int         HOLE_HEIGHT       = game_params::HOLE_HEIGHT,
    parameter logic [2:0] WALL_COLOUR       = game_params::WALL_COLOUR,
    parameter logic [2:0] BACKGROUND_COLOUR = game_params::BACKGROUND_COLOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       erase,
    input  logic [7:0] wall_x,
    input  logic [6:0] hole_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot
);

    import game_params::*;

    localparam int c_COL_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
    localparam int c_ROW_W = 7;

    render_state_t      r_state;
    logic [7:0]         r_wall_x;
    logic [6:0]         r_hole_y;
    logic               r_erase;

    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_last;
    logic               w_clear;
    logic               w_scan;
    logic [8:0]         w_px;
    logic [7:0]         w_row8;
    logic [7:0]         w_hole_lo;
    logic [7:0]         w_hole_hi;
    logic               w_in_hole;

    assign w_scan  = (r_state == SCAN);
    assign w_clear = (r_state == IDLE) && start;

    raster_counter #(
        .WIDTH  (WALL_WIDTH),
        .HEIGHT (SCREEN_H),
        .COL_W  (c_COL_W),
        .ROW_W  (c_ROW_W)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .en    (w_scan),
        .col   (w_col),
        .row   (w_row),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_wall_x <= '0;
            r_hole_y <= '0;
            r_erase  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wall_x <= wall_x;
                        r_hole_y <= hole_y;
                        r_erase  <= erase;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // 9-bit x so walls straddling the right edge clip instead of wrapping
    assign w_px      = {1'b0, r_wall_x} + 9'(w_col);
    assign w_row8    = {1'b0, w_row};
    assign w_hole_lo = {1'b0, r_hole_y};
    assign w_hole_hi = w_hole_lo + 8'(HOLE_HEIGHT);
    assign w_in_hole = (w_row8 >= w_hole_lo) && (w_row8 < w_hole_hi);

    assign busy       = (r_state == SCAN) || (r_state == DONE);
    assign done       = (r_state == DONE);
    assign plot       = w_scan && (w_px < 9'(SCREEN_W));
    assign x_out      = w_scan ? w_px[7:0] : 8'd0;
    assign y_out      = w_scan ? w_row : 7'd0;
    assign colour_out = !w_scan              ? 3'b000 :
                        (r_erase || w_in_hole) ? BACKGROUND_COLOUR : WALL_COLOUR;

endmodule

`default_nettype wire

// File: tb/tb_wall_renderer.sv
// ============================================================================
// Module      : tb_wall_renderer
// Description : Self-checking bench with a pixel scoreboard for wall_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wall_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       erase;
    logic [7:0] wall_x;
    logic [6:0] hole_y;
    logic       busy;
    logic       done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;

    wall_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .erase      (erase),
        .wall_x     (wall_x),
        .hole_y     (hole_y),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [7:0] wx;
        logic [6:0] hy;
        logic       er;
        int         exp_plots;
    } vec_t;

    pix_t       exp_q[$];
    pix_t       exp_last;
    pix_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_plots = 0;
    logic [7:0] last_x;
    logic [6:0] last_y;
    logic [2:0] seen [0:255][0:127];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every plot strobe must match the oldest expected pixel
    always @(negedge clk) begin
        if (plot) begin
            n_plots++;
            last_x = x_out;
            last_y = y_out;
            seen[x_out][y_out] = colour_out;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) expected none",
                         x_out, y_out, colour_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({x_out, y_out, colour_out} != mon_e) begin
                    n_fail++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             x_out, y_out, colour_out, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    task automatic push_pass(input logic [7:0] wx, input logic [6:0] hy, input logic er);
        pix_t p;
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < 120; r++) begin
                int px;
                px = int'(wx) + c;
                if (px < 160) begin
                    p.x = 8'(px);
                    p.y = 7'(r);
                    if (er)                                     p.c = 3'b111;
                    else if (r >= int'(hy) && r < int'(hy) + 50) p.c = 3'b111;
                    else                                        p.c = 3'b100;
                    exp_q.push_back(p);
                    exp_last = p;
                end
            end
        end
    endtask

    task automatic run_pass(input logic [7:0] wx, input logic [6:0] hy, input logic er,
                            input int exp_plots, input int inj_cycle, input logic [7:0] inj_wx);
        int cyc;
        int p0;
        @(posedge clk);
        #1;
        wall_x = wx;
        hole_y = hy;
        erase  = er;
        start  = 1'b1;
        push_pass(wx, hy, er);
        p0 = n_plots;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wall_x = ~wx;
        hole_y = ~hy;
        erase  = ~er;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("first_busy", int'(busy), 1);
                check("first_plot", int'(plot), 1);
                check("first_x", int'(x_out), int'(wx));
                check("first_y", int'(y_out), 0);
            end
            if (inj_cycle != 0 && cyc == inj_cycle) begin
                start  = 1'b1;
                wall_x = inj_wx;
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 1300);
        check("done_cycle", cyc, 1201);
        check("busy_at_done", int'(busy), 1);
        check("plot_count", n_plots - p0, exp_plots);
        check("queue_drained", exp_q.size(), 0);
        check("last_x", int'(last_x), int'(exp_last.x));
        check("last_y", int'(last_y), int'(exp_last.y));
    endtask

    initial begin
        vec_t vecs[4];
        int   cyc;
        int   p0;
        int   n_done;

        vecs[0] = '{wx: 8'd100, hy: 7'd30,  er: 1'b0, exp_plots: 1200};
        vecs[1] = '{wx: 8'd155, hy: 7'd0,   er: 1'b0, exp_plots: 600};
        vecs[2] = '{wx: 8'd40,  hy: 7'd0,   er: 1'b1, exp_plots: 1200};
        vecs[3] = '{wx: 8'd60,  hy: 7'd100, er: 1'b0, exp_plots: 1200};

        reset  = 1'b1;
        start  = 1'b0;
        erase  = 1'b0;
        wall_x = '0;
        hole_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        check("rst_colour", int'(colour_out), 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_pass(vecs[i].wx, vecs[i].hy, vecs[i].er, vecs[i].exp_plots, 0, 8'd0);
            @(negedge clk);
            check("done_pulse_width", int'(done), 0);
            check("idle_busy", int'(busy), 0);
        end

        check("draw_row29", int'(seen[100][29]), 4);
        check("draw_row30", int'(seen[100][30]), 7);
        check("draw_row79", int'(seen[100][79]), 7);
        check("draw_row80", int'(seen[100][80]), 4);
        check("draw_last", int'(seen[109][119]), 4);
        check("erase_mid", int'(seen[45][60]), 7);
        check("ovf_row99", int'(seen[60][99]), 4);
        check("ovf_row100", int'(seen[60][100]), 7);
        check("ovf_row119", int'(seen[69][119]), 7);

        // Start mid-pass is ignored; the back-to-back start at cycle 1202 is taken
        run_pass(8'd100, 7'd30, 1'b0, 1200, 300, 8'd20);
        run_pass(8'd20, 7'd5, 1'b0, 1200, 0, 8'd0);

        // Abort with reset at cycle 500
        @(posedge clk);
        #1;
        wall_x = 8'd50;
        hole_y = 7'd10;
        erase  = 1'b0;
        start  = 1'b1;
        push_pass(8'd50, 7'd10, 1'b0);
        p0 = n_plots;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("abort_plot_count", n_plots - p0, 500);
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_x", int'(x_out), 0);
        check("abort_y", int'(y_out), 0);
        check("abort_colour", int'(colour_out), 0);
        n_done = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Reset and start together: reset wins
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", int'(busy), 0);
        check("rst_start_plot", int'(plot), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
